// File: rtl/button_conditioner_pkg.sv
// Shared state encoding and 24 MHz default timing constants for the button conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;    // 10 ms at 24 MHz
    localparam int unsigned DEF_LONG_CYCLES     = 24000000;  // 1 s at 24 MHz

endpackage

// File: rtl/button_conditioner_sync.sv
// Two-flop synchroniser with a configurable reset level, reusable for any async pin.
module sync_2ff #(
    parameter logic P_RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] ff_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ff_q <= {2{P_RESET_VAL}};
        end else begin
            ff_q <= {ff_q[0], i_d};
        end
    end

    assign o_q = ff_q[1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release pulses.
// Optional long-press pulse enabled by defining BUTTON_LONG_PRESS_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned P_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned P_LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          P_ACTIVE_LOW      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned CNT_W = (P_DEBOUNCE_CYCLES > 2) ? $clog2(P_DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_DEBOUNCE_CYCLES - 1);

    if (P_LONG_CYCLES <= P_DEBOUNCE_CYCLES) begin : g_bad_long
        $error("P_LONG_CYCLES must exceed P_DEBOUNCE_CYCLES");
    end

    logic       sync_out;
    logic       p;
    btn_state_e state_q;
    logic [CNT_W-1:0] cnt_q;

    // Reset the synchroniser to the released level so reset never looks like a press.
    sync_2ff #(
        .P_RESET_VAL (P_ACTIVE_LOW)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_button),
        .o_q     (sync_out)
    );

    assign p = sync_out ^ P_ACTIVE_LOW;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned LONG_W = $clog2(P_LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(P_LONG_CYCLES);

    logic [LONG_W-1:0] long_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            long_q <= '0;
            o_long <= 1'b0;
        end else begin
            o_long <= 1'b0;
            if (state_q == ST_HELD && p) begin
                // Saturating, so the pulse fires once per accepted press.
                if (long_q != LONG_MAX) begin
                    long_q <= long_q + 1'b1;
                end
                if (long_q == LONG_MAX - 1'b1) begin
                    o_long <= 1'b1;
                end
            end else if (state_q == ST_IDLE ||
                         (state_q == ST_RELEASE_WAIT && !p && cnt_q == CNT_MAX)) begin
                long_q <= '0;
            end
        end
    end
`else
    assign o_long = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (p) begin
                        state_q <= ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!p) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                        o_press <= 1'b1;
                        o_level <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    cnt_q <= '0;
                    if (!p) begin
                        state_q <= ST_RELEASE_WAIT;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (p) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        o_release <= 1'b1;
                        o_level   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long-press timing.
module tb_button_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic btn_al;
    logic level, press, release_p, long_p;
    logic level_al, press_al, release_al, long_al;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .P_DEBOUNCE_CYCLES (DEB),
        .P_LONG_CYCLES     (LONG),
        .P_ACTIVE_LOW      (1'b0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_button  (button),
        .o_level   (level),
        .o_press   (press),
        .o_release (release_p),
        .o_long    (long_p)
    );

    button_conditioner #(
        .P_DEBOUNCE_CYCLES (DEB),
        .P_LONG_CYCLES     (LONG),
        .P_ACTIVE_LOW      (1'b1)
    ) dut_al (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_button  (btn_al),
        .o_level   (level_al),
        .o_press   (press_al),
        .o_release (release_al),
        .o_long    (long_al)
    );

    typedef struct {
        logic raw;
        logic lvl;
        logic prs;
        logic rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic raw, input logic lvl, input logic prs, input logic rel);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input int i,
                            input logic lvl, input logic prs, input logic rel, input logic lng);
        chk($sformatf("%s[%0d].level", tag, i), level, lvl);
        chk($sformatf("%s[%0d].press", tag, i), press, prs);
        chk($sformatf("%s[%0d].release", tag, i), release_p, rel);
        chk($sformatf("%s[%0d].long", tag, i), long_p, lng);
    endtask

    initial begin
        // Bounced press then bounced release; index i = outputs after edge i.
        add(1,0,0,0); add(1,0,0,0); add(0,0,0,0); add(1,0,0,0); add(1,0,0,0);
        add(1,0,0,0); add(1,0,0,0); add(1,0,0,0); add(1,0,0,0); add(1,1,1,0);
        add(1,1,0,0); add(1,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0);
        add(1,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0);
        add(0,1,0,0); add(0,1,0,0); add(0,0,0,1); add(0,0,0,0); add(0,0,0,0);

        rst_n  = 1'b0;
        button = 1'b0;
        btn_al = 1'b1;
        repeat (3) step();
        chk_main("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) step();
        chk_main("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            button = tbl[i].raw;
            step();
            chk_main("bounce", i, tbl[i].lvl, tbl[i].prs, tbl[i].rel, 1'b0);
        end

        // Clean press held long enough to cross the long-press threshold.
        button = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step();
            chk_main("hold", i, logic'(i >= 6), logic'(i == 6), 1'b0,
                     logic'(LONG_EN && i == 26));
        end

        button = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_main("rel", i, logic'(i < 6), 1'b0, logic'(i == 6), 1'b0);
        end

        // Second press: the long counter must have been cleared by the release.
        button = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk_main("repress", i, logic'(i >= 6), logic'(i == 6), 1'b0,
                     logic'(LONG_EN && i == 26));
        end

        // Asynchronous reset while held; the button stays pressed throughout.
        #3;
        rst_n = 1'b0;
        #1;
        chk_main("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_main("postrst", i, logic'(i >= 6), logic'(i == 6), 1'b0, 1'b0);
        end

        // Active-low instance: released pin reads 1, so reset must not yield a press.
        rst_n  = 1'b0;
        btn_al = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("al_idle[%0d].press", i), press_al, 1'b0);
            chk($sformatf("al_idle[%0d].level", i), level_al, 1'b0);
        end
        btn_al = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("al_press[%0d].press", i), press_al, logic'(i == 6));
            chk($sformatf("al_press[%0d].level", i), level_al, logic'(i >= 6));
            chk($sformatf("al_press[%0d].release", i), release_al, 1'b0);
        end
        chk("al.long", long_al, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
